// File: rtl/wb_master_pkg.sv
// Types and constants shared by the Wishbone command master, its timer and its bench.
package wb_master_pkg;

    localparam int DEF_ADR_W  = 4;
    localparam int DEF_DATA_W = 32;

    // Value the downstream slave treats as "halt forever"; also used by the bench.
    localparam logic [31:0] HALT_PATTERN = 32'hCAFEBABE;

    typedef enum logic [1:0] {
        IDLE,
        STROBE,
        WAIT_ACK,
        RESP
    } state_e;

endpackage

// File: rtl/wb_timeout_timer.sv
// Watchdog counter for the WAIT_ACK phase: counts enabled cycles and flags the
// last tolerated one so the master can give up on a slave that never acks.
module wb_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int                CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_q, count_d;

    // Count holds at LAST so a stalled master can never wrap back to a non-expired value.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != LAST)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = enable && (count_q == LAST);

endmodule

// File: rtl/wishbone_cmd_master.sv
// Wishbone master: one single-beat Wishbone transaction per accepted command, with the
// read data (or a timeout error) returned on a valid/ready response stream.
module wishbone_cmd_master
    import wb_master_pkg::*;
#(
    parameter int ADR_W          = DEF_ADR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ERR_CNT_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_we,
    input  logic [ADR_W-1:0]     cmd_adr,
    input  logic [DATA_W-1:0]    cmd_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DATA_W-1:0]    rsp_rdata,
    output logic                 rsp_err,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [ADR_W-1:0]     adr,
    output logic [DATA_W-1:0]    dat_mosi,
    input  logic [DATA_W-1:0]    dat_miso,
    output logic                 we,
    output logic                 cyc,
    output logic                 stb,
    input  logic                 ack
);

    state_e                 state_q, state_d;
    logic                   cyc_q, cyc_d;
    logic                   stb_q, stb_d;
    logic                   we_q, we_d;
    logic [ADR_W-1:0]       adr_q, adr_d;
    logic [DATA_W-1:0]      dat_mosi_q, dat_mosi_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic                   rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0]      rsp_rdata_q, rsp_rdata_d;
    logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;

    logic timer_clear;
    logic timer_en;
    logic timer_expired;

    assign timer_en    = (state_q == WAIT_ACK);
    assign timer_clear = !timer_en;

    wb_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (timer_clear),
        .enable (timer_en),
        .expired(timer_expired)
    );

    always_comb begin
        // NOTE: every _d starts as its _q so no branch can leave a signal unassigned (no latches).
        state_d     = state_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        we_d        = we_q;
        adr_d       = adr_q;
        dat_mosi_d  = dat_mosi_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        err_cnt_d   = err_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d    = STROBE;
                    cyc_d      = 1'b1;
                    stb_d      = 1'b1;
                    we_d       = cmd_we;
                    adr_d      = cmd_adr;
                    dat_mosi_d = cmd_wdata;
                end
            end
            // Strobe lasts one cycle only: the slave acks every strobed cycle.
            // Any ack seen here belongs to an earlier transaction and is dropped.
            STROBE: begin
                state_d    = WAIT_ACK;
                stb_d      = 1'b0;
                dat_mosi_d = '0;
            end
            WAIT_ACK: begin
                if (ack) begin
                    state_d     = RESP;
                    cyc_d       = 1'b0;
                    we_d        = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = dat_miso;
                end else if (timer_expired) begin
                    state_d     = RESP;
                    cyc_d       = 1'b0;
                    we_d        = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                    if (err_cnt_q != '1) begin
                        err_cnt_d = err_cnt_q + 1'b1;
                    end
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_mosi_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            dat_mosi_q  <= dat_mosi_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign cyc       = cyc_q;
    assign stb       = stb_q;
    assign we        = we_q;
    assign adr       = adr_q;
    assign dat_mosi  = dat_mosi_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_wishbone_cmd_master.sv
// Scoreboard bench for wishbone_cmd_master: a halting register-file slave on the bus,
// a register-array reference model feeding an expected-response queue, and bus monitors.
module tb_wishbone_cmd_master;
    import wb_master_pkg::*;

    localparam int ADR_W          = 4;
    localparam int DATA_W         = 32;
    localparam int TIMEOUT_CYCLES = 16;
    localparam int ERR_CNT_W      = 8;
    localparam int ERR_MAX        = (1 << ERR_CNT_W) - 1;
    localparam int N_REGS         = 1 << ADR_W;

    typedef struct {
        logic [DATA_W-1:0]    rdata;
        logic                 err;
        logic [ERR_CNT_W-1:0] err_cnt;
    } exp_t;

    logic                 clk;
    logic                 rst_n;
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic                 cmd_we;
    logic [ADR_W-1:0]     cmd_adr;
    logic [DATA_W-1:0]    cmd_wdata;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [DATA_W-1:0]    rsp_rdata;
    logic                 rsp_err;
    logic [ERR_CNT_W-1:0] err_cnt;
    logic [ADR_W-1:0]     adr;
    logic [DATA_W-1:0]    dat_mosi;
    logic [DATA_W-1:0]    dat_miso;
    logic                 we;
    logic                 cyc;
    logic                 stb;
    logic                 ack;

    wishbone_cmd_master #(
        .ADR_W         (ADR_W),
        .DATA_W        (DATA_W),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .ERR_CNT_W     (ERR_CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_we   (cmd_we),
        .cmd_adr  (cmd_adr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .err_cnt  (err_cnt),
        .adr      (adr),
        .dat_mosi (dat_mosi),
        .dat_miso (dat_miso),
        .we       (we),
        .cyc      (cyc),
        .stb      (stb),
        .ack      (ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc_count = 0;
    always @(posedge clk) cyc_count <= cyc_count + 1;

    // Bus slave: acks the cycle after a strobe with the pre-write register value,
    // and stops acking for good once it is written the halt pattern.
    logic [DATA_W-1:0] s_mem [N_REGS];
    logic              s_ack;
    logic              s_halted;
    logic              inj_ack;

    assign ack = s_ack | inj_ack;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_ack    <= 1'b0;
            s_halted <= 1'b0;
            dat_miso <= '0;
            for (int i = 0; i < N_REGS; i++) s_mem[i] <= '0;
        end else begin
            s_ack <= 1'b0;
            if (cyc && stb && !s_halted) begin
                s_ack    <= 1'b1;
                dat_miso <= s_mem[adr];
                if (we) begin
                    s_mem[adr] <= dat_mosi;
                    if (dat_mosi == HALT_PATTERN) s_halted <= 1'b1;
                end
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: register array plus halted flag and saturating error count.
    logic [DATA_W-1:0] m_mem [N_REGS];
    bit                m_halted;
    int                m_err;
    exp_t              sb_q [$];

    task automatic model_reset();
        for (int i = 0; i < N_REGS; i++) m_mem[i] = '0;
        m_halted = 1'b0;
        m_err    = 0;
    endtask

    task automatic model_issue(input logic w, input logic [ADR_W-1:0] a, input logic [DATA_W-1:0] d);
        exp_t e;
        if (m_halted) begin
            e.rdata = '0;
            e.err   = 1'b1;
            if (m_err < ERR_MAX) m_err++;
        end else begin
            e.rdata = m_mem[a];
            e.err   = 1'b0;
            if (w) begin
                m_mem[a] = d;
                if (d == HALT_PATTERN) m_halted = 1'b1;
            end
        end
        e.err_cnt = ERR_CNT_W'(m_err);
        sb_q.push_back(e);
    endtask

    // rsp_ready driver: changes only on falling edges, with a settable acceptance rate.
    int rdy_pct = 100;
    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            rsp_ready = ($urandom_range(99) < rdy_pct);
        end
    end

    // Response monitor: every handshake pops and compares one expected response.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && rsp_valid && rsp_ready) begin
                if (sb_q.size() == 0) begin
                    check("rsp_queue_depth", sb_q.size(), 1);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("rsp_rdata", rsp_rdata, e.rdata);
                    check("rsp_err", rsp_err, e.err);
                    check("rsp_err_cnt", err_cnt, e.err_cnt);
                end
            end
        end
    end

    // Bus-rule monitor: one-cycle strobes, strobe only inside cyc, zero write data off-strobe.
    int  stb_pulses = 0;
    int  bus_viol   = 0;
    bit  prev_stb   = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (stb && prev_stb) bus_viol++;
            if (stb && !cyc) bus_viol++;
            if (!stb && (dat_mosi != '0)) bus_viol++;
            if (stb && !prev_stb) stb_pulses++;
            prev_stb = stb;
        end
    end

    int accept_cyc = 0;
    int n_accepted = 0;

    task automatic send(input logic w, input logic [ADR_W-1:0] a, input logic [DATA_W-1:0] d);
        int k = 0;
        @(negedge clk);
        cmd_we    = w;
        cmd_adr   = a;
        cmd_wdata = d;
        cmd_valid = 1'b1;
        while (!cmd_ready && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (!cmd_ready) begin
            check("cmd_ready_wait", cmd_ready, 1'b1);
            $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
            $fatal(1, "command never accepted");
        end
        @(posedge clk);
        model_issue(w, a, d);
        n_accepted++;
        #1;
        accept_cyc = cyc_count;
    endtask

    task automatic drop_valid();
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic set_rdy(input int p);
        @(posedge clk);
        #1;
        rdy_pct = p;
    endtask

    task automatic wait_rsp(input string name, output int lat);
        int k = 0;
        do begin
            @(negedge clk);
            #1;
            k++;
        end while (!rsp_valid && k < 60);
        check({name, "_rsp_seen"}, rsp_valid, 1'b1);
        lat = cyc_count - accept_cyc;
    endtask

    initial begin
        int                lat;
        int                seen;
        int                k;
        int                t_acc [8];
        logic              w;
        logic [ADR_W-1:0]  a;
        logic [DATA_W-1:0] d;

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_adr   = '0;
        cmd_wdata = '0;
        inj_ack   = 1'b0;
        model_reset();

        #2;
        check("rst_cyc", cyc, 1'b0);
        check("rst_stb", stb, 1'b0);
        check("rst_we", we, 1'b0);
        check("rst_adr", adr, 0);
        check("rst_dat_mosi", dat_mosi, 0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_err", rsp_err, 1'b0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_cmd_ready", cmd_ready, 1'b1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Write then read back, with accept-to-response latency.
        send(1'b1, 4'd3, 32'h12345678);
        drop_valid();
        send(1'b0, 4'd3, 32'h0BAD0BAD);
        drop_valid();
        wait_rsp("t1", lat);
        check("t1_latency", lat, 2);
        check("t1_rdata", rsp_rdata, 32'h12345678);
        check("t1_err", rsp_err, 1'b0);

        // Back-pressure: response held stable, bus idle, no new command taken.
        set_rdy(0);
        send(1'b0, 4'd3, 32'h0);
        drop_valid();
        wait_rsp("t2", lat);
        repeat (5) begin
            @(negedge clk);
            #1;
            check("t2_rsp_valid_hold", rsp_valid, 1'b1);
            check("t2_rdata_hold", rsp_rdata, 32'h12345678);
            check("t2_cmd_ready", cmd_ready, 1'b0);
            check("t2_cyc", cyc, 1'b0);
            check("t2_stb", stb, 1'b0);
        end
        set_rdy(100);

        // Halt pattern passes through unchanged; next read times out.
        send(1'b1, 4'd1, HALT_PATTERN);
        check("t3_strobe_stb", stb, 1'b1);
        check("t3_strobe_data", dat_mosi, HALT_PATTERN);
        check("t3_strobe_adr", adr, 1);
        check("t3_strobe_we", we, 1'b1);
        drop_valid();
        send(1'b0, 4'd1, 32'h0);
        inj_ack = 1'b1;              // stale ack during STROBE must be ignored
        @(posedge clk);
        #1;
        inj_ack = 1'b0;
        drop_valid();
        wait_rsp("t3", lat);
        check("t3_latency", lat, TIMEOUT_CYCLES + 1);
        check("t3_err", rsp_err, 1'b1);
        check("t3_rdata", rsp_rdata, 0);
        check("t3_err_cnt", err_cnt, 1);

        // Reset in the middle of WAIT_ACK discards the command.
        @(posedge clk);
        #1;
        send(1'b0, 4'd5, 32'h0);
        drop_valid();
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("t4_cyc_async", cyc, 1'b0);
        check("t4_stb_async", stb, 1'b0);
        check("t4_rsp_valid_async", rsp_valid, 1'b0);
        sb_q.delete();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        inj_ack = 1'b1;
        #1;
        check("t4_cmd_ready", cmd_ready, 1'b1);
        check("t4_err_cnt", err_cnt, 0);
        @(negedge clk);
        inj_ack = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            #1;
            if (rsp_valid || cyc) seen++;
        end
        check("t4_no_response", seen, 0);

        // Back-to-back commands: one accept every 4 cycles.
        for (int i = 0; i < 8; i++) begin
            w = 1'($urandom_range(1));
            a = ADR_W'($urandom_range(N_REGS - 1));
            d = $urandom;
            if (d == HALT_PATTERN) d = ~d;
            send(w, a, d);
            t_acc[i] = accept_cyc;
        end
        drop_valid();
        for (int i = 1; i < 8; i++) check("t5_interval", t_acc[i] - t_acc[i-1], 4);

        // Random commands with random gaps and random back-pressure.
        set_rdy(60);
        repeat (40) begin
            w = 1'($urandom_range(1));
            a = ADR_W'($urandom_range(N_REGS - 1));
            d = $urandom;
            if (d == HALT_PATTERN) d = ~d;
            send(w, a, d);
            if ($urandom_range(2) == 0) begin
                drop_valid();
                repeat ($urandom_range(3)) @(negedge clk);
            end
        end
        drop_valid();
        set_rdy(100);

        // Halted slave: the error counter saturates instead of wrapping.
        send(1'b1, 4'd2, HALT_PATTERN);
        drop_valid();
        repeat (ERR_MAX + 5) begin
            send(1'b0, ADR_W'($urandom_range(N_REGS - 1)), 32'h0);
            drop_valid();
        end

        k = 0;
        while (sb_q.size() != 0 && k < 200) begin
            @(negedge clk);
            #2;
            k++;
        end
        check("t6_err_cnt_sat", err_cnt, ERR_MAX);
        check("end_queue_empty", sb_q.size(), 0);
        check("end_stb_pulses", stb_pulses, n_accepted);
        check("end_bus_rules", bus_viol, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
